// File: rtl/acc_cpu_p_pkg.sv
// Shared types for the accumulator CPU: opcode encoding and FSM states.
// The optional multiplier is enabled by defining ACC_CPU_P_MUL_EN.
package acc_cpu_p_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JC   = 4'hB,
    OP_SHL  = 4'hC,
    OP_SHR  = 4'hD,
    OP_MUL  = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_OPERAND = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  localparam int OPCODE_W = 4;
  localparam int INSTR_W  = 8;

endpackage

// File: rtl/acc_cpu_p_alu.sv
// Combinational ALU for acc_cpu_p; the MUL path exists only when
// ACC_CPU_P_MUL_EN is defined, otherwise opcode E passes acc/C through.
module acc_cpu_p_alu
  import acc_cpu_p_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] operand,
  input  logic          c_in,
  output logic [DW-1:0] result,
  output logic          c_out
);

  logic [DW:0] sum;
`ifdef ACC_CPU_P_MUL_EN
  logic [2*DW-1:0] prod;
`endif

  always_comb begin
    result = acc;
    c_out  = c_in;
    sum    = '0;
`ifdef ACC_CPU_P_MUL_EN
    prod   = '0;
`endif
    case (opcode_t'(op))
      OP_ADD: begin
        sum    = {1'b0, acc} + {1'b0, operand};
        result = sum[DW-1:0];
        c_out  = sum[DW];
      end
      OP_SUB: begin
        // borrow is simply the unsigned compare
        result = acc - operand;
        c_out  = (acc < operand);
      end
      OP_AND: begin result = acc & operand; c_out = 1'b0; end
      OP_OR:  begin result = acc | operand; c_out = 1'b0; end
      OP_XOR: begin result = acc ^ operand; c_out = 1'b0; end
      OP_SHL: begin result = {acc[DW-2:0], 1'b0}; c_out = acc[DW-1]; end
      OP_SHR: begin result = {1'b0, acc[DW-1:1]}; c_out = acc[0]; end
`ifdef ACC_CPU_P_MUL_EN
      OP_MUL: begin
        prod   = {{DW{1'b0}}, acc} * {{DW{1'b0}}, operand};
        result = prod[DW-1:0];
        c_out  = |prod[2*DW-1:DW];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_cpu_p.sv
// Byte-serial accumulator CPU: FETCH/OPERAND/HALT FSM, NREG registers, flags.
// Define ACC_CPU_P_MUL_EN to turn opcode E into MUL (otherwise it is a NOP).
module acc_cpu_p
  import acc_cpu_p_pkg::*;
#(
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int NREG = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    instr,
  input  logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] acc,
  output logic          zero,
  output logic          carry,
  output logic          halted,
  output logic [1:0]    state_dbg
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  state_t          state_q, state_d;
  opcode_t         pend_q, pend_d;
  logic [AW-1:0]   pc_q, pc_d, pc_inc, imm_aw;
  logic [DW-1:0]   acc_q, acc_d, imm_dw, operand_r, alu_res;
  logic            z_q, z_d, c_q, c_d, alu_c, alu_wb, reg_we;
  logic [DW-1:0]   regs_q [NREG];
  opcode_t         opc;
  logic [RW-1:0]   r_sel;

  assign opc       = opcode_t'(instr[7:4]);
  assign r_sel     = instr[RW-1:0];
  assign operand_r = regs_q[r_sel];
  assign imm_dw    = DW'(instr);
  assign imm_aw    = AW'(instr);
  assign pc_inc    = pc_q + AW'(1);

  acc_cpu_p_alu #(.DW(DW)) u_alu (
    .op      (instr[7:4]),
    .acc     (acc_q),
    .operand (operand_r),
    .c_in    (c_q),
    .result  (alu_res),
    .c_out   (alu_c)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    z_d     = z_q;
    c_d     = c_q;
    reg_we  = 1'b0;
    alu_wb  = 1'b0;
    if (instr_valid) begin
      case (state_q)
        ST_FETCH: begin
          pc_d = pc_inc;
          case (opc)
            OP_LDI, OP_JMP, OP_JZ, OP_JC: begin
              state_d = ST_OPERAND;
              pend_d  = opc;
            end
            OP_LD: begin
              acc_d = operand_r;
              z_d   = (operand_r == '0);
            end
            OP_ST: reg_we = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: alu_wb = 1'b1;
`ifdef ACC_CPU_P_MUL_EN
            OP_MUL: alu_wb = 1'b1;
`endif
            OP_HALT: begin
              pc_d    = pc_q;
              state_d = ST_HALT;
            end
            default: ;
          endcase
          if (alu_wb) begin
            acc_d = alu_res;
            c_d   = alu_c;
            z_d   = (alu_res == '0);
          end
        end
        ST_OPERAND: begin
          state_d = ST_FETCH;
          pend_d  = OP_NOP;
          pc_d    = pc_inc;
          case (pend_q)
            OP_LDI: begin
              acc_d = imm_dw;
              z_d   = (imm_dw == '0);
            end
            OP_JMP: pc_d = imm_aw;
            OP_JZ:  pc_d = z_q ? imm_aw : pc_inc;
            OP_JC:  pc_d = c_q ? imm_aw : pc_inc;
            default: ;
          endcase
        end
        default: ;  // HALT accepts nothing until reset
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pend_q  <= OP_NOP;
      pc_q    <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      c_q     <= c_d;
      if (reg_we) regs_q[r_sel] <= acc_q;
    end
  end

  assign pc        = pc_q;
  assign acc       = acc_q;
  assign zero      = z_q;
  assign carry     = c_q;
  assign halted    = (state_q == ST_HALT);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_acc_cpu_p.sv
// Bench for acc_cpu_p: byte-stream driver, high-level reference model,
// expected-state queue drained by a monitor after each clock edge.
module tb_acc_cpu_p;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr;
  logic       instr_valid;
  logic [7:0] pc, acc;
  logic       zero, carry, halted;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  acc_cpu_p dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .acc         (acc),
    .zero        (zero),
    .carry       (carry),
    .halted      (halted),
    .state_dbg   (state_dbg)
  );

  int checks   = 0;
  int failures = 0;
  logic [18:0] exp_q[$];

  // reference machine state as plain integers
  int m_pc, m_acc, m_z, m_c, m_halt, m_pend;
  int m_r[4];

  task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got halt=%0b c=%0b z=%0b acc=%02h pc=%02h, expected halt=%0b c=%0b z=%0b acc=%02h pc=%02h",
               name, got[18], got[17], got[16], got[15:8], got[7:0],
               exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
    end
  endtask

  function automatic logic [18:0] model_vec();
    logic [7:0] a, p;
    a = 8'(m_acc);
    p = 8'(m_pc);
    return {(m_halt != 0), (m_c != 0), (m_z != 0), a, p};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_halt = 0; m_pend = -1;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
  endtask

  task automatic model_step(input logic [7:0] b);
    int op, r, v, p;
    bit wr;
    if (m_halt != 0) return;
    if (m_pend >= 0) begin
      case (m_pend)
        1:  begin m_acc = int'(b); m_z = (m_acc == 0); m_pc = (m_pc + 1) % 256; end
        9:  m_pc = int'(b);
        10: m_pc = (m_z != 0) ? int'(b) : (m_pc + 1) % 256;
        11: m_pc = (m_c != 0) ? int'(b) : (m_pc + 1) % 256;
        default: ;
      endcase
      m_pend = -1;
      return;
    end
    op = int'(b) / 16;
    r  = int'(b) % 4;
    v  = m_r[r];
    wr = 1'b0;
    m_pc = (m_pc + 1) % 256;
    case (op)
      1, 9, 10, 11: m_pend = op;
      2:  begin m_acc = v; wr = 1'b1; end
      3:  m_r[r] = m_acc;
      4:  begin p = m_acc + v; m_c = (p > 255); m_acc = p % 256; wr = 1'b1; end
      5:  begin m_c = (m_acc < v); m_acc = (m_acc - v + 256) % 256; wr = 1'b1; end
      6:  begin m_acc = m_acc & v; m_c = 0; wr = 1'b1; end
      7:  begin m_acc = m_acc | v; m_c = 0; wr = 1'b1; end
      8:  begin m_acc = m_acc ^ v; m_c = 0; wr = 1'b1; end
      12: begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256; wr = 1'b1; end
      13: begin m_c = m_acc % 2; m_acc = m_acc / 2; wr = 1'b1; end
`ifdef ACC_CPU_P_MUL_EN
      14: begin p = m_acc * v; m_c = (p > 255); m_acc = p % 256; wr = 1'b1; end
`endif
      15: begin m_halt = 1; m_pc = (m_pc + 255) % 256; end
      default: ;
    endcase
    if (wr) m_z = (m_acc == 0);
  endtask

  task automatic drive(input logic [7:0] b, input logic v);
    @(negedge clk);
    instr       = b;
    instr_valid = v;
    if (v) model_step(b);
    exp_q.push_back(model_vec());
  endtask

  task automatic do_reset();
    @(negedge clk);
    instr_valid = 1'b0;
    reset       = 1'b0;
    #1;
    model_reset();
    check("reset_state", {halted, carry, zero, acc, pc}, model_vec());
    checks++;
    if (state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL reset_fsm: got state=%0d, expected state=0", state_dbg);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_prog(input logic [7:0] prog[$]);
    foreach (prog[i]) drive(prog[i], 1'b1);
  endtask

  // monitor: each edge after a driven cycle presents a new architectural state
  initial begin
    logic [18:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("step", {halted, carry, zero, acc, pc}, e);
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic v;
    int budget;
    reset = 1'b0;
    instr = 8'h00;
    instr_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_reset();
    // store/add/halt program, then bytes offered to a halted core
    run_prog('{8'h10, 8'h05, 8'h34, 8'h10, 8'hFB, 8'h44, 8'hF0});
    repeat (3) drive(8'h10, 1'b1);
    do_reset();
    // subtract with borrow
    run_prog('{8'h10, 8'h05, 8'h30, 8'h10, 8'h03, 8'h50});
    do_reset();
    // JZ taken, then not taken
    run_prog('{8'h10, 8'h00, 8'hA0, 8'h08});
    do_reset();
    run_prog('{8'h10, 8'h01, 8'hA0, 8'h08});
    do_reset();
    // stall between opcode and operand
    drive(8'h10, 1'b1);
    repeat (3) drive(8'h99, 1'b0);
    drive(8'h2A, 1'b1);
    do_reset();
    // reset while an operand is pending
    run_prog('{8'h10, 8'h07, 8'h90});
    do_reset();
    run_prog('{8'h10, 8'h2A});
    do_reset();
    // opcode E with R1=10, acc=20
    run_prog('{8'h10, 8'h10, 8'h31, 8'h10, 8'h20, 8'hE1});
    do_reset();

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) < 2 || (m_halt != 0 && $urandom_range(0, 5) == 0)) begin
        do_reset();
      end else begin
        b = 8'($urandom_range(0, 255));
        if (b[7:4] == 4'hF && $urandom_range(0, 3) != 0) b[7:4] = 4'h4;
        v = ($urandom_range(0, 9) < 8);
        drive(b, v);
      end
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
